// File: rtl/uart_pkg.sv
// Shared UART types, constants and baud divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Rounded clk/(baud*os), never below 1.
   function automatic int calc_tick_div(input int clk_hz,
                                        input int baud,
                                        input int os);
      int d;
      d = (clk_hz + (baud * os) / 2) / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; one-clk pulse every TICK_DIV clocks.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
)(
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int CW       = $clog2(TICK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // With TICK_DIV=1 the counter sits at 0 and tick stays high.
   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with one-entry valid/ready output.
// Define UART_RX_PARITY_EN for an 8-bit + parity frame and parity_err.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
   ,parameter bit PARITY_ODD = 1'b0
`endif
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
`ifdef UART_RX_PARITY_EN
   ,output logic      parity_err
`endif
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic tick;
   logic sync1;
   logic rx_s;

   rx_state_t state, state_n;
   logic [SW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [UART_DATA_BITS-1:0] shift, shift_n;
   logic deliver;
   logic ferr;
`ifdef UART_RX_PARITY_EN
   logic par, par_n;
   logic perr;
`endif

   uart_baud_tick #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx_in;
         rx_s  <= sync1;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
`ifdef UART_RX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
`ifdef UART_RX_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shift_n = shift;
      deliver = 1'b0;
      ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n   = par;
      perr    = 1'b0;
`endif
      if (tick) begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  cnt_n   = '0;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt_n = '0;
                  idx_n = '0;
                  // Line high at mid start bit means it was a glitch.
                  state_n = rx_s ? IDLE : DATA;
               end else begin
                  cnt_n = cnt + SW'(1);
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt_n   = '0;
                  shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
                  idx_n   = idx + 3'd1;
                  if (idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_n = PARITY;
`else
                     state_n = STOP;
`endif
                  end
               end else begin
                  cnt_n = cnt + SW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == FULL_M1) begin
                  cnt_n   = '0;
                  par_n   = rx_s;
                  state_n = STOP;
               end else begin
                  cnt_n = cnt + SW'(1);
               end
            end
`endif
            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt_n = '0;
                  if (!rx_s) begin
                     ferr    = 1'b1;
                     state_n = BREAK;
                  end else begin
                     state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                     if (((^shift) ^ par) != PARITY_ODD) begin
                        perr = 1'b1;
                     end else begin
                        deliver = 1'b1;
                     end
`else
                     deliver = 1'b1;
`endif
                  end
               end else begin
                  cnt_n = cnt + SW'(1);
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= ferr;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= perr;
`endif
         if (deliver) begin
            // A same-cycle transfer frees the slot for the new byte.
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at 16 clk per bit.
module tb_uart_rx_os;

   localparam int CLK_HZ = 1843200;
   localparam int BAUD   = 115200;
   localparam int OS     = 16;
   localparam int BT     = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   always #5 clk = ~clk;

   uart_rx_os #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
`ifdef UART_RX_PARITY_EN
      ,.parity_err (parity_err)
`endif
   );

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         ferr;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int n_ferr = 0;
   int n_ovr = 0;
   int n_perr = 0;
   int n_rise = 0;
   int t_start = 0;
   int t_rise = -1;
   bit busy_seen = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_xfer = 1'b0;
   logic [7:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Output monitor: scoreboard pops on each transfer.
   always @(negedge clk) begin
      if (!reset) begin
         if (busy) busy_seen = 1'b1;
         if (frame_err) n_ferr++;
         if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) n_perr++;
`endif
         if (rx_valid && !prev_valid) begin
            n_rise++;
            t_rise = cyc;
         end
         if (rx_valid && prev_valid && !prev_xfer)
            check("hold", {24'd0, rx_data}, {24'd0, prev_data});
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got %0h, required none",
                        rx_data);
            end else begin
               check("data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_valid = rx_valid;
         prev_xfer  = rx_valid && rx_ready;
         prev_data  = rx_data;
      end else begin
         prev_valid = 1'b0;
         prev_xfer  = 1'b0;
      end
   end

   task automatic send_bit(input logic b);
      rx_in = b;
      repeat (BT) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // par < 0 sends the correct even parity bit in parity builds.
   task automatic frame(input logic [7:0] d,
                        input logic stop,
                        input int par);
      rx_in = 1'b0;
      t_start = cyc;
      repeat (BT) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      if (par < 0) send_bit(^d);
      else send_bit(par[0]);
`else
      if (par > 1) send_bit(1'b1);
`endif
      send_bit(stop);
   endtask

   task automatic clr();
      n_ferr = 0;
      n_ovr = 0;
      n_perr = 0;
      n_rise = 0;
      t_rise = -1;
   endtask

   initial begin
      vec_t tbl[6];
      int lat;
      tbl[0] = '{8'hA5, 1'b1, 0};
      tbl[1] = '{8'h00, 1'b1, 0};
      tbl[2] = '{8'hFF, 1'b1, 0};
      tbl[3] = '{8'h5A, 1'b1, 0};
      tbl[4] = '{8'hC3, 1'b0, 1};
      tbl[5] = '{8'h80, 1'b1, 0};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", {24'd0, rx_data}, 32'd0);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      idle(20);

      // Table of single frames, consumer always ready.
      for (int i = 0; i < 6; i++) begin
         clr();
         if (tbl[i].stop) exp_q.push_back(tbl[i].d);
         frame(tbl[i].d, tbl[i].stop, -1);
         idle(32);
         check("ferr_cnt", n_ferr, tbl[i].ferr);
         check("ovr_cnt", n_ovr, 0);
         check("valid_rise", n_rise, {31'd0, tbl[i].stop});
         check("q_empty", exp_q.size(), 0);
         check("valid_low", {31'd0, rx_valid}, 32'd0);
         if (tbl[i].stop) begin
            lat = t_rise - t_start;
            check("latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
         end
      end

      // Back-to-back with consumer stalled: second byte overruns.
      clr();
      rx_ready = 1'b0;
      exp_q.push_back(8'h3C);
      frame(8'h3C, 1'b1, -1);
      frame(8'h7E, 1'b1, -1);
      idle(32);
      check("ovr_once", n_ovr, 1);
      check("ovr_valid", {31'd0, rx_valid}, 32'd1);
      check("ovr_data", {24'd0, rx_data}, 32'h3C);
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      check("ovr_drain", {31'd0, rx_valid}, 32'd0);
      check("ovr_q", exp_q.size(), 0);
      rx_ready = 1'b1;
      idle(8);

      // Bad stop bit followed by a held-low line.
      clr();
      frame(8'h55, 1'b0, -1);
      rx_in = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      idle(32);
      check("brk_ferr", n_ferr, 1);
      check("brk_novalid", n_rise, 0);
      clr();
      exp_q.push_back(8'h01);
      frame(8'h01, 1'b1, -1);
      idle(32);
      check("brk_next", n_rise, 1);
      check("brk_q", exp_q.size(), 0);

      // Short glitch is rejected at mid start bit.
      clr();
      busy_seen = 1'b0;
      rx_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      idle(40);
      check("gl_busy_seen", {31'd0, busy_seen}, 32'd1);
      check("gl_busy_low", {31'd0, busy}, 32'd0);
      check("gl_novalid", n_rise, 0);
      check("gl_noferr", n_ferr, 0);

      // Held byte plus a partial frame, then async reset.
      rx_ready = 1'b0;
      frame(8'h99, 1'b1, -1);
      idle(32);
      check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
      rx_in = 1'b0;
      repeat (BT) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx_in = 1'b1;
      repeat (BT / 2) @(posedge clk);
      #1;
      check("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("ar_valid", {31'd0, rx_valid}, 32'd0);
      check("ar_data", {24'd0, rx_data}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_ferr", {31'd0, frame_err}, 32'd0);
      check("ar_ovr", {31'd0, overrun}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      rx_ready = 1'b1;
      idle(32);
      clr();
      exp_q.push_back(8'h81);
      frame(8'h81, 1'b1, -1);
      idle(32);
      check("post_rst_rise", n_rise, 1);
      check("post_rst_q", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
      clr();
      exp_q.push_back(8'h07);
      frame(8'h07, 1'b1, 1);
      idle(32);
      check("par_ok_rise", n_rise, 1);
      check("par_ok_perr", n_perr, 0);
      clr();
      frame(8'h07, 1'b1, 0);
      idle(32);
      check("par_bad_perr", n_perr, 1);
      check("par_bad_rise", n_rise, 0);
      check("par_q", exp_q.size(), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
